// File: rtl/butterfly_r2_pipe.sv
`default_nettype none
// ============================================================================
// Module : butterfly_r2_pipe
// Brief  : 3-stage radix-2 DIT/DIF complex butterfly with run-time twiddles,
//          optional 1/2 scaling, saturation and a sticky overflow flag.
// Rev    : 1.0
// ============================================================================
module butterfly_r2_pipe #(
    parameter int DATA_WIDTH = 16,
    parameter int TW_WIDTH   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_valid,
    input  logic                         mode,
    input  logic                         scale,
    input  logic signed [DATA_WIDTH-1:0] a_re,
    input  logic signed [DATA_WIDTH-1:0] a_im,
    input  logic signed [DATA_WIDTH-1:0] b_re,
    input  logic signed [DATA_WIDTH-1:0] b_im,
    input  logic signed [TW_WIDTH-1:0]   tw_re,
    input  logic signed [TW_WIDTH-1:0]   tw_im,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] y0_re,
    output logic signed [DATA_WIDTH-1:0] y0_im,
    output logic signed [DATA_WIDTH-1:0] y1_re,
    output logic signed [DATA_WIDTH-1:0] y1_im,
    output logic                         ovf,
    input  logic                         ovf_clr
);

    localparam int c_xw = DATA_WIDTH + 1;
    localparam int c_pw = c_xw + TW_WIDTH + 1;
    localparam int c_rw = DATA_WIDTH + 2;
    localparam logic signed [c_pw-1:0] c_rnd  = c_pw'(1) <<< (TW_WIDTH - 2);
    localparam logic signed [c_rw-1:0] c_smax = {3'b000, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [c_rw-1:0] c_smin = ~c_smax;

    function automatic logic signed [c_rw-1:0] half_up(input logic signed [c_rw-1:0] v);
        logic signed [c_rw-1:0] inc;
        inc = v + c_rw'(1);
        return inc >>> 1;
    endfunction

    function automatic logic clips(input logic signed [c_rw-1:0] v);
        return (v > c_smax) || (v < c_smin);
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] sat(input logic signed [c_rw-1:0] v);
        if (v > c_smax) return c_smax[DATA_WIDTH-1:0];
        if (v < c_smin) return c_smin[DATA_WIDTH-1:0];
        return v[DATA_WIDTH-1:0];
    endfunction

    // stage 1: x carries a (DIT) or s (DIF), p carries b (DIT) or d (DIF)
    logic                       v1_q, v1_d, mode1_q, mode1_d, scale1_q, scale1_d;
    logic signed [c_xw-1:0]     x1_re_q, x1_re_d, x1_im_q, x1_im_d;
    logic signed [c_xw-1:0]     p1_re_q, p1_re_d, p1_im_q, p1_im_d;
    logic signed [TW_WIDTH-1:0] tw1_re_q, tw1_re_d, tw1_im_q, tw1_im_d;
    // stage 2
    logic                       v2_q, v2_d, mode2_q, mode2_d, scale2_q, scale2_d;
    logic signed [c_xw-1:0]     x2_re_q, x2_re_d, x2_im_q, x2_im_d;
    logic signed [c_pw-1:0]     m2_re_q, m2_re_d, m2_im_q, m2_im_d;
    // outputs
    logic                         out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic signed [DATA_WIDTH-1:0] y0_re_q, y0_re_d, y0_im_q, y0_im_d;
    logic signed [DATA_WIDTH-1:0] y1_re_q, y1_re_d, y1_im_q, y1_im_d;

    logic signed [c_xw-1:0] w_a_re, w_a_im, w_b_re, w_b_im;
    logic signed [c_pw-1:0] w_p_re, w_p_im, w_tw_re, w_tw_im, w_r_re, w_r_im;
    logic signed [c_rw-1:0] w_t_re, w_t_im, w_x_re, w_x_im;
    logic signed [c_rw-1:0] w_y0_re, w_y0_im, w_y1_re, w_y1_im;
    logic                   w_clip;

    always_comb begin
        w_a_re   = c_xw'(a_re);
        w_a_im   = c_xw'(a_im);
        w_b_re   = c_xw'(b_re);
        w_b_im   = c_xw'(b_im);
        v1_d     = v1_q;
        mode1_d  = mode1_q;
        scale1_d = scale1_q;
        x1_re_d  = x1_re_q;
        x1_im_d  = x1_im_q;
        p1_re_d  = p1_re_q;
        p1_im_d  = p1_im_q;
        tw1_re_d = tw1_re_q;
        tw1_im_d = tw1_im_q;
        if (en) begin
            v1_d     = in_valid;
            mode1_d  = mode;
            scale1_d = scale;
            tw1_re_d = tw_re;
            tw1_im_d = tw_im;
            if (mode) begin
                x1_re_d = w_a_re + w_b_re;
                x1_im_d = w_a_im + w_b_im;
                p1_re_d = w_a_re - w_b_re;
                p1_im_d = w_a_im - w_b_im;
            end else begin
                x1_re_d = w_a_re;
                x1_im_d = w_a_im;
                p1_re_d = w_b_re;
                p1_im_d = w_b_im;
            end
        end
    end

    always_comb begin
        w_p_re   = c_pw'(p1_re_q);
        w_p_im   = c_pw'(p1_im_q);
        w_tw_re  = c_pw'(tw1_re_q);
        w_tw_im  = c_pw'(tw1_im_q);
        v2_d     = v2_q;
        mode2_d  = mode2_q;
        scale2_d = scale2_q;
        x2_re_d  = x2_re_q;
        x2_im_d  = x2_im_q;
        m2_re_d  = m2_re_q;
        m2_im_d  = m2_im_q;
        if (en) begin
            v2_d     = v1_q;
            mode2_d  = mode1_q;
            scale2_d = scale1_q;
            x2_re_d  = x1_re_q;
            x2_im_d  = x1_im_q;
            m2_re_d  = w_p_re * w_tw_re - w_p_im * w_tw_im;
            m2_im_d  = w_p_re * w_tw_im + w_p_im * w_tw_re;
        end
    end

    always_comb begin
        w_r_re  = m2_re_q + c_rnd;
        w_r_im  = m2_im_q + c_rnd;
        w_t_re  = c_rw'(w_r_re >>> (TW_WIDTH - 1));
        w_t_im  = c_rw'(w_r_im >>> (TW_WIDTH - 1));
        w_x_re  = c_rw'(x2_re_q);
        w_x_im  = c_rw'(x2_im_q);
        w_y0_re = mode2_q ? w_x_re : w_x_re + w_t_re;
        w_y0_im = mode2_q ? w_x_im : w_x_im + w_t_im;
        w_y1_re = mode2_q ? w_t_re : w_x_re - w_t_re;
        w_y1_im = mode2_q ? w_t_im : w_x_im - w_t_im;
        if (scale2_q) begin
            w_y0_re = half_up(w_y0_re);
            w_y0_im = half_up(w_y0_im);
            w_y1_re = half_up(w_y1_re);
            w_y1_im = half_up(w_y1_im);
        end
        w_clip = clips(w_y0_re) | clips(w_y0_im) | clips(w_y1_re) | clips(w_y1_im);

        out_valid_d = out_valid_q;
        y0_re_d     = y0_re_q;
        y0_im_d     = y0_im_q;
        y1_re_d     = y1_re_q;
        y1_im_d     = y1_im_q;
        if (en) begin
            out_valid_d = v2_q;
            y0_re_d     = sat(w_y0_re);
            y0_im_d     = sat(w_y0_im);
            y1_re_d     = sat(w_y1_re);
            y1_im_d     = sat(w_y1_im);
        end
        // clear works regardless of en; a simultaneous set takes priority
        ovf_d = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (en && v2_q && w_clip) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            y0_re_q     <= '0;
            y0_im_q     <= '0;
            y1_re_q     <= '0;
            y1_im_q     <= '0;
        end else begin
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            y0_re_q     <= y0_re_d;
            y0_im_q     <= y0_im_d;
            y1_re_q     <= y1_re_d;
            y1_im_q     <= y1_im_d;
        end
    end

    always_ff @(posedge clk) begin
        mode1_q  <= mode1_d;
        scale1_q <= scale1_d;
        x1_re_q  <= x1_re_d;
        x1_im_q  <= x1_im_d;
        p1_re_q  <= p1_re_d;
        p1_im_q  <= p1_im_d;
        tw1_re_q <= tw1_re_d;
        tw1_im_q <= tw1_im_d;
        mode2_q  <= mode2_d;
        scale2_q <= scale2_d;
        x2_re_q  <= x2_re_d;
        x2_im_q  <= x2_im_d;
        m2_re_q  <= m2_re_d;
        m2_im_q  <= m2_im_d;
    end

    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign y0_re     = y0_re_q;
    assign y0_im     = y0_im_q;
    assign y1_re     = y1_re_q;
    assign y1_im     = y1_im_q;

endmodule
`default_nettype wire

// File: tb/tb_butterfly_r2_pipe.sv
`default_nettype none
// ============================================================================
// Module : tb_butterfly_r2_pipe
// Brief  : self-checking bench for butterfly_r2_pipe against an arithmetic model
// Rev    : 1.0
// ============================================================================
module tb_butterfly_r2_pipe;

    localparam int DW = 16;
    localparam int TW = 16;

    logic clk = 1'b0;
    logic rst, en, in_valid, mode, scale, ovf_clr;
    logic signed [DW-1:0] a_re, a_im, b_re, b_im;
    logic signed [TW-1:0] tw_re, tw_im;
    logic                 out_valid, ovf;
    logic signed [DW-1:0] y0_re, y0_im, y1_re, y1_im;

    butterfly_r2_pipe #(.DATA_WIDTH(DW), .TW_WIDTH(TW)) dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .mode(mode), .scale(scale),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .tw_re(tw_re), .tw_im(tw_im),
        .out_valid(out_valid), .y0_re(y0_re), .y0_im(y0_im), .y1_re(y1_re), .y1_im(y1_im),
        .ovf(ovf), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    typedef struct { longint ar, ai, br, bi, twr, twi; bit md, sc; } smp_t;
    typedef struct { bit v; longint y0r, y0i, y1r, y1i; bit clip; } exp_t;

    exp_t  pipe_m[3];   // expected contents after 1, 2, 3 accepted edges
    bit    ovf_m;
    smp_t  cur;
    int    errors = 0;
    int    checks = 0;
    logic [4*DW-1:0] exp_y, got_y;

    function automatic longint wrapn(longint v, int n);
        longint m;
        m = v & ((longint'(1) << n) - 1);
        if (m >= (longint'(1) << (n - 1))) m -= (longint'(1) << n);
        return m;
    endfunction

    function automatic exp_t ref_model(smp_t s, bit vld);
        longint xr, xi, pr, pi, mr, mi, tr, ti;
        longint y[4];
        longint maxv, minv;
        exp_t e;
        maxv = (longint'(1) << (DW - 1)) - 1;
        minv = -(longint'(1) << (DW - 1));
        if (s.md) begin
            xr = s.ar + s.br; xi = s.ai + s.bi; pr = s.ar - s.br; pi = s.ai - s.bi;
        end else begin
            xr = s.ar; xi = s.ai; pr = s.br; pi = s.bi;
        end
        mr = pr * s.twr - pi * s.twi;
        mi = pr * s.twi + pi * s.twr;
        tr = wrapn((mr + (longint'(1) << (TW - 2))) >>> (TW - 1), DW + 2);
        ti = wrapn((mi + (longint'(1) << (TW - 2))) >>> (TW - 1), DW + 2);
        y[0] = s.md ? xr : wrapn(xr + tr, DW + 2);
        y[1] = s.md ? xi : wrapn(xi + ti, DW + 2);
        y[2] = s.md ? tr : wrapn(xr - tr, DW + 2);
        y[3] = s.md ? ti : wrapn(xi - ti, DW + 2);
        e.clip = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (s.sc) y[i] = wrapn(y[i] + 1, DW + 2) >>> 1;
            if (y[i] > maxv) begin y[i] = maxv; e.clip = 1'b1; end
            if (y[i] < minv) begin y[i] = minv; e.clip = 1'b1; end
        end
        e.v = vld; e.y0r = y[0]; e.y0i = y[1]; e.y1r = y[2]; e.y1i = y[3];
        return e;
    endfunction

    function automatic logic [4*DW-1:0] pack(exp_t e);
        return {DW'(e.y0r), DW'(e.y0i), DW'(e.y1r), DW'(e.y1i)};
    endfunction

    function automatic smp_t mk(longint ar, longint ai, longint br, longint bi,
                                longint twr, longint twi, bit md, bit sc);
        smp_t s;
        s.ar = ar; s.ai = ai; s.br = br; s.bi = bi; s.twr = twr; s.twi = twi; s.md = md; s.sc = sc;
        return s;
    endfunction

    function automatic smp_t rnd_smp();
        smp_t s;
        int sh;
        sh = $urandom_range(0, 8);
        s.ar  = $signed(DW'($urandom)) >>> sh;
        s.ai  = $signed(DW'($urandom)) >>> sh;
        s.br  = $signed(DW'($urandom)) >>> sh;
        s.bi  = $signed(DW'($urandom)) >>> sh;
        s.twr = $signed(TW'($urandom));
        s.twi = $signed(TW'($urandom));
        s.md  = 1'($urandom);
        s.sc  = 1'($urandom);
        return s;
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < 3; i++) begin
            pipe_m[i].v = 1'b0; pipe_m[i].clip = 1'b0;
            pipe_m[i].y0r = 0; pipe_m[i].y0i = 0; pipe_m[i].y1r = 0; pipe_m[i].y1i = 0;
        end
        ovf_m = 1'b0;
    endfunction

    task automatic put(smp_t s, bit vld);
        a_re = DW'(s.ar); a_im = DW'(s.ai); b_re = DW'(s.br); b_im = DW'(s.bi);
        tw_re = TW'(s.twr); tw_im = TW'(s.twi);
        mode = s.md; scale = s.sc; in_valid = vld; cur = s;
    endtask

    // one clock: update the model from the inputs seen at the edge, return at negedge
    task automatic adv();
        @(posedge clk);
        if (rst) begin
            clear_model();
        end else if (en) begin
            if (pipe_m[1].v && pipe_m[1].clip) ovf_m = 1'b1;
            else if (ovf_clr)                  ovf_m = 1'b0;
            pipe_m[2] = pipe_m[1];
            pipe_m[1] = pipe_m[0];
            pipe_m[0] = ref_model(cur, in_valid);
        end else if (ovf_clr) begin
            ovf_m = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b expected=0", out_valid); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset ovf got=%b expected=0", ovf); end
        checks++;
        got_y = {y0_re, y0_im, y1_re, y1_im};
        if (got_y !== '0) begin errors++; $display("FAIL reset outputs got=%h expected=0", got_y); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        en  = 1'b1;
    endtask

    task automatic test_directed();
        smp_t tbl[$];
        bit   vl[$];
        smp_t bub;
        bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl.push_back(mk(1000, 200, 400, -600, 16384, 0, 0, 0));   vl.push_back(1);
        tbl.push_back(bub);                                        vl.push_back(0);
        tbl.push_back(bub);                                        vl.push_back(0);
        tbl.push_back(bub);                                        vl.push_back(0);
        tbl.push_back(mk(1000, 200, 400, -600, 0, -32768, 0, 0));  vl.push_back(1);
        tbl.push_back(mk(1000, 200, 400, -600, 16384, 0, 1, 0));   vl.push_back(1);
        tbl.push_back(bub);                                        vl.push_back(0);
        tbl.push_back(mk(3, -3, 0, 0, 16384, 0, 0, 1));            vl.push_back(1);
        tbl.push_back(mk(0, 0, 1, 0, 16384, 0, 0, 0));             vl.push_back(1);
        for (int i = 0; i < tbl.size() + 3; i++) begin
            if (i < tbl.size()) put(tbl[i], vl[i]); else put(bub, 1'b0);
            adv();
            checks++;
            if (out_valid !== pipe_m[2].v) begin
                errors++; $display("FAIL directed[%0d] out_valid got=%b expected=%b", i, out_valid, pipe_m[2].v);
            end
            if (pipe_m[2].v) begin
                checks++;
                exp_y = pack(pipe_m[2]); got_y = {y0_re, y0_im, y1_re, y1_im};
                if (got_y !== exp_y) begin errors++; $display("FAIL directed[%0d] y got=%h expected=%h", i, got_y, exp_y); end
            end
            checks++;
            if (ovf !== ovf_m) begin errors++; $display("FAIL directed[%0d] ovf got=%b expected=%b", i, ovf, ovf_m); end
        end
    endtask

    task automatic test_saturation();
        smp_t sat0, sat1, bub;
        sat0 = mk(32000, 0, 32000, 0, -32768, 0, 0, 0);
        sat1 = mk(32000, 0, 32000, 0, -32768, 0, 0, 1);
        bub  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            ovf_clr = (i == 6);
            if (i == 0)      put(sat0, 1'b1);
            else if (i == 8) put(sat1, 1'b1);
            else             put(bub, 1'b0);
            adv();
            checks++;
            if (out_valid !== pipe_m[2].v) begin
                errors++; $display("FAIL sat[%0d] out_valid got=%b expected=%b", i, out_valid, pipe_m[2].v);
            end
            if (pipe_m[2].v) begin
                checks++;
                exp_y = pack(pipe_m[2]); got_y = {y0_re, y0_im, y1_re, y1_im};
                if (got_y !== exp_y) begin errors++; $display("FAIL sat[%0d] y got=%h expected=%h", i, got_y, exp_y); end
            end
            checks++;
            if (ovf !== ovf_m) begin errors++; $display("FAIL sat[%0d] ovf got=%b expected=%b", i, ovf, ovf_m); end
            if (i == 5) begin
                checks++;
                if (ovf !== 1'b1) begin errors++; $display("FAIL sat sticky ovf got=%b expected=1", ovf); end
            end
            if (i == 11) begin
                checks++;
                if (ovf !== 1'b0) begin errors++; $display("FAIL sat scaled ovf got=%b expected=0", ovf); end
            end
        end
        ovf_clr = 1'b0;
    endtask

    task automatic test_stall();
        smp_t bub;
        bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            en = !(i >= 3 && i <= 6);
            if (i < 3 || !en) put(rnd_smp(), 1'b1); else put(bub, 1'b0);
            adv();
            checks++;
            if (out_valid !== pipe_m[2].v) begin
                errors++; $display("FAIL stall[%0d] out_valid got=%b expected=%b", i, out_valid, pipe_m[2].v);
            end
            if (pipe_m[2].v) begin
                checks++;
                exp_y = pack(pipe_m[2]); got_y = {y0_re, y0_im, y1_re, y1_im};
                if (got_y !== exp_y) begin errors++; $display("FAIL stall[%0d] y got=%h expected=%h", i, got_y, exp_y); end
            end
            checks++;
            if (ovf !== ovf_m) begin errors++; $display("FAIL stall[%0d] ovf got=%b expected=%b", i, ovf, ovf_m); end
        end
        en = 1'b1;
    endtask

    task automatic test_reset_inflight();
        smp_t bub;
        bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            if (i < 3) put(rnd_smp(), 1'b1); else put(bub, 1'b0);
            if (i == 3) begin
                #2 rst = 1'b1;
                #1;
                clear_model();
                checks++;
                if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_inflight out_valid got=%b expected=0", out_valid); end
                checks++;
                got_y = {y0_re, y0_im, y1_re, y1_im};
                if (got_y !== '0 || ovf !== 1'b0) begin
                    errors++; $display("FAIL rst_inflight outputs got=%h ovf=%b expected=0", got_y, ovf);
                end
            end
            if (i == 5) rst = 1'b0;
            adv();
            checks++;
            if (out_valid !== pipe_m[2].v) begin
                errors++; $display("FAIL rst_inflight[%0d] out_valid got=%b expected=%b", i, out_valid, pipe_m[2].v);
            end
            if (pipe_m[2].v) begin
                checks++;
                exp_y = pack(pipe_m[2]); got_y = {y0_re, y0_im, y1_re, y1_im};
                if (got_y !== exp_y) begin errors++; $display("FAIL rst_inflight[%0d] y got=%h expected=%h", i, got_y, exp_y); end
            end
        end
    endtask

    task automatic test_random();
        smp_t bub;
        bub = mk(0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 404; i++) begin
            if (i < 400) begin
                en      = ($urandom_range(0, 4) != 0);
                ovf_clr = ($urandom_range(0, 15) == 0);
                put(rnd_smp(), 1'($urandom));
            end else begin
                en = 1'b1; ovf_clr = 1'b0;
                put(bub, 1'b0);
            end
            adv();
            checks++;
            if (out_valid !== pipe_m[2].v) begin
                errors++; $display("FAIL random[%0d] out_valid got=%b expected=%b", i, out_valid, pipe_m[2].v);
            end
            if (pipe_m[2].v) begin
                checks++;
                exp_y = pack(pipe_m[2]); got_y = {y0_re, y0_im, y1_re, y1_im};
                if (got_y !== exp_y) begin errors++; $display("FAIL random[%0d] y got=%h expected=%h", i, got_y, exp_y); end
            end
            checks++;
            if (ovf !== ovf_m) begin errors++; $display("FAIL random[%0d] ovf got=%b expected=%b", i, ovf, ovf_m); end
        end
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; in_valid = 1'b0; mode = 1'b0; scale = 1'b0; ovf_clr = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; tw_re = '0; tw_im = '0;
        clear_model();
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_directed();
        test_saturation();
        test_stall();
        test_reset_inflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
